retire_trace_buffer: RTL
========================

# retire_trace_buffer

Synthesizable retirement-trace recorder for the pipelined CPU. It sits beside the MEM/WB boundary and captures each retiring event into a parametrised circular buffer: register writes, loads, stores and halt, each stamped with the cycle number. The same counters and event records the simulation trace provides therefore stay available in hardware, and a downstream debug port drains the buffer over a valid/ready handshake. It adds selectable stop-when-full or overwrite-oldest behaviour, drop accounting and a halt freeze.

## Interface
Parameters:
- DATA_W, 16, width of register data, memory address and memory data
- REG_W, 4, register-id width
- DEPTH, 8, number of entries; power of two, at least 2
- CNT_W, 32, width of the cycle, instruction and drop counters and the cycle stamp
- MODE, 0, full-buffer policy: 0 drops new events when full; 1 overwrites the oldest entry

Ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- clear, in, 1, synchronous flush of buffer, counters, sticky flags and halted
- en, in, 1, capture and instruction-count enable
- reg_write, in, 1, register write retiring this cycle
- reg_id, in, REG_W, destination register
- reg_data, in, DATA_W, write-back data
- mem_read, in, 1, load in the memory stage
- mem_write, in, 1, store in the memory stage
- mem_addr, in, DATA_W, memory address
- mem_rdata, in, DATA_W, load data
- mem_wdata, in, DATA_W, store data
- halt, in, 1, halt reached in the memory or write-back stage
- rd_valid, out, 1, head entry available
- rd_ready, in, 1, consumer accepts the head entry
- rd_flags, out, 4, {halt, mem_write, mem_read, reg_write}
- rd_reg, out, REG_W, head register id
- rd_reg_data, out, DATA_W, head register data
- rd_mem_addr, out, DATA_W, head memory address
- rd_mem_data, out, DATA_W, head memory data (store data if mem_write, else load data)
- rd_cycle, out, CNT_W, cycle stamp of the head entry
- count, out, log2(DEPTH)+1, occupancy
- cycle_count, out, CNT_W, cycles since reset or clear
- inst_count, out, CNT_W, retired instructions
- drop_count, out, CNT_W, events lost or overwritten; saturates
- overflow, out, 1, sticky: set when any event is dropped or overwritten
- proto_err, out, 1, sticky: set when mem_read and mem_write are high together
- halted, out, 1, sticky: a halt was captured

## Operation
- Memory legality: the cycle is a load only when mem_read & ~mem_write, and a store only when mem_write & ~mem_read. If both are high, neither memory flag is recorded and proto_err is set.
- Event: a cycle is an event when en & ~halted & (reg_write | legal load | legal store | halt).
- Entry contents: the four flags, the data fields and rd_cycle = cycle_count before that edge. Unused fields are stored as presented.
- inst_count increments on each event with reg_write, store or halt set; a load-only event is not counted.
- cycle_count increments every edge while ~halted, independent of en.
- Halt: the halt event is captured normally (subject to the full policy), then halted is set. Once halted, capture stops and cycle_count and inst_count freeze. Draining continues.
- Pop: rd_valid & rd_ready advances the head.
- Full with push and no pop:
  - MODE 0: the new event is dropped; drop_count increments and overflow is set.
  - MODE 1: the oldest entry is replaced and the head advances, so count stays DEPTH; drop_count increments and overflow is set.
- Full with push and pop in the same cycle: the pop frees a slot and the push is stored. No drop in either mode.
- Empty with push and pop in the same cycle: the pop is ignored because rd_valid is 0. The push is stored.
- Pointers wrap modulo DEPTH. count = write pointer minus read pointer, using one extra wrap bit.
- drop_count saturates at all-ones.
- clear has priority over capture and pop on the same edge.

## Timing
- Reset (async, immediate): rd_valid=0, count=0, all counters 0, overflow=0, proto_err=0, halted=0, pointers 0, rd_* outputs 0.
- Capture-to-visible latency is 1 cycle: an event sampled at edge N gives rd_valid=1 after edge N when the buffer was empty.
- Show-ahead: rd_* reflect the head entry combinationally from storage, with no extra read cycle.
- In MODE 1, an overwrite while full changes the rd_* head contents after the edge; rd_valid stays 1.
- Reset asserted mid-drain discards all entries. rd_valid falls with reset, not on the next edge.

## Test plan
- DEPTH=4, MODE=0; reg_write r3=0x00AB at cycle 5 -> after edge, rd_valid=1, rd_flags=0001, rd_reg=3, rd_reg_data=0x00AB, rd_cycle=5, inst_count=1.
- MODE=0; 6 events with rd_ready=0 -> count=4, entries hold events 1-4, drop_count=2, overflow=1; drain returns events 1-4 in order.
- MODE=1; 6 events with rd_ready=0 -> count=4, drain returns events 3-6, drop_count=2.
- Full buffer plus simultaneous push and pop -> count stays 4, drop_count unchanged, new event appears last.
- mem_read=mem_write=1 with reg_write=0 -> no entry, proto_err=1, inst_count unchanged. Load 0x0040/0x1234 -> rd_flags=0010, inst_count unchanged.
- Halt at cycle 20 -> halt entry has rd_cycle=20, halted=1. cycle_count stays 21 thereafter and later events are ignored. rst_n pulsed low mid-drain -> every output returns to 0 immediately.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// Retirement-trace recorder. Captures register writes, loads, stores and
// halt from the MEM/WB boundary into a circular buffer stamped with the
// cycle number, and exposes the oldest entry show-ahead on a valid/ready
// drain port. Full policy (drop new / overwrite oldest) is set by MODE.
module retire_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32,
  parameter int MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     reg_write,
  input  logic [REG_W-1:0]         reg_id,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [DATA_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic [DATA_W-1:0]        mem_wdata,
  input  logic                     halt,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [3:0]               rd_flags,
  output logic [REG_W-1:0]         rd_reg,
  output logic [DATA_W-1:0]        rd_reg_data,
  output logic [DATA_W-1:0]        rd_mem_addr,
  output logic [DATA_W-1:0]        rd_mem_data,
  output logic [CNT_W-1:0]         rd_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         inst_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow,
  output logic                     proto_err,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // One trace record; flags are {halt, store, load, reg_write}.
  typedef struct packed {
    logic [3:0]        flags;
    logic [REG_W-1:0]  regId;
    logic [DATA_W-1:0] regData;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic [CNT_W-1:0]  cycle;
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      newEntry;
  entry_t      head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;

  logic        isLoad;
  logic        isStore;
  logic        memConflict;
  logic        isEvent;
  logic        full;
  logic        pop;
  logic        pushOk;
  logic        overwrite;
  logic        dropEv;
  logic        writeSlot;
  logic        countsInst;

  // A load and a store in the same cycle is illegal; neither is recorded.
  assign memConflict = mem_read & mem_write;
  assign isLoad      = mem_read & ~mem_write;
  assign isStore     = mem_write & ~mem_read;
  assign isEvent     = en & ~halted & (reg_write | isLoad | isStore | halt);
  assign countsInst  = isEvent & (reg_write | isStore | halt);

  assign count    = wrPtr - rdPtr;
  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;

  // A same-cycle pop frees the slot, so a push while full only loses data
  // when nothing drains. In overwrite mode the oldest entry is replaced and
  // the head moves past it.
  assign pushOk    = isEvent & (~full | pop);
  assign dropEv    = isEvent & full & ~pop;
  assign overwrite = dropEv & (MODE == 1);
  assign writeSlot = pushOk | overwrite;

  // Record built from what is presented this cycle; memData follows the
  // recorded store flag so a conflict cycle keeps the load-data bus value.
  always_comb begin
    newEntry         = '0;
    newEntry.flags   = {halt, isStore, isLoad, reg_write};
    newEntry.regId   = reg_id;
    newEntry.regData = reg_data;
    newEntry.memAddr = mem_addr;
    newEntry.memData = isStore ? mem_wdata : mem_rdata;
    newEntry.cycle   = cycle_count;
  end

  // Storage array; contents are don't-care until covered by the pointers.
  always_ff @(posedge clk) begin
    if (writeSlot && !clear) mem[wrPtr[AW-1:0]] <= newEntry;
  end

  // Show-ahead head read; outputs are held at zero while the buffer is empty.
  always_comb begin
    head        = mem[rdPtr[AW-1:0]];
    rd_flags    = '0;
    rd_reg      = '0;
    rd_reg_data = '0;
    rd_mem_addr = '0;
    rd_mem_data = '0;
    rd_cycle    = '0;
    if (rd_valid) begin
      rd_flags    = head.flags;
      rd_reg      = head.regId;
      rd_reg_data = head.regData;
      rd_mem_addr = head.memAddr;
      rd_mem_data = head.memData;
      rd_cycle    = head.cycle;
    end
  end

  // Pointer movement; clear wins over capture and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (writeSlot)        wrPtr <= wrPtr + 1'b1;
      if (pop || overwrite) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Cycle and instruction counters; both freeze once a halt is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      inst_count  <= '0;
    end else if (clear) begin
      cycle_count <= '0;
      inst_count  <= '0;
    end else begin
      if (!halted)    cycle_count <= cycle_count + 1'b1;
      if (countsInst) inst_count  <= inst_count + 1'b1;
    end
  end

  // Loss accounting: saturating drop counter plus sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (dropEv) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  // Sticky status: protocol error and halt freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
      halted    <= 1'b0;
    end else if (clear) begin
      proto_err <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (memConflict)    proto_err <= 1'b1;
      if (isEvent && halt) halted   <= 1'b1;
    end
  end

endmodule
